// File: rtl/alu_seq_display.sv
// Sequential ALU with operand registers, shift-add multiplier, start/busy/done
// handshake, status flags and a multiplexed active-low hex display driver.
module alu_seq_display #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     operand_in,
    input  logic [2:0]           opcode,
    input  logic                 load_a,
    input  logic                 load_b,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 zero,
    output logic                 neg,
    output logic                 carry,
    output logic                 ovf,
    output logic [6:0]           seg_cat,
    output logic [DIGITS-1:0]    seg_an
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_INC,
        OP_SUB,
        OP_MUL,
        OP_NOT,
        OP_XOR,
        OP_OR,
        OP_AND
    } op_t;

    state_t             state_q;
    state_t             state_d;
    op_t                op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      count_q;
    logic               done_q;
    logic               complete;
    logic               accept;
    logic               mul_step;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     inc;
    logic [2*WIDTH-1:0] a_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;

    logic [2*WIDTH-1:0] res_d;
    logic               zero_d;
    logic               neg_d;
    logic               carry_d;
    logic               ovf_d;

    logic [RW-1:0]      ref_q;
    logic [IW-1:0]      idx_q;
    logic [PW-1:0]      res_pad;
    logic [3:0]         nib;
    logic [DIGITS-1:0]  an_hot;

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign accept   = (state_q == IDLE) && start;
    assign mul_step = (state_q == MUL) && (count_q != CW'(WIDTH));

    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (opcode == 3'(OP_MUL)) ? MUL : EXEC;
                end
            end
            EXEC: begin
                state_d  = IDLE;
                complete = 1'b1;
            end
            MUL: begin
                if (count_q == CW'(WIDTH)) begin
                    state_d  = IDLE;
                    complete = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands are snapshotted at start so a same-cycle load only affects the next op.
    assign sum   = {1'b0, opa_q} + {1'b0, opb_q};
    assign diff  = {1'b0, opa_q} - {1'b0, opb_q};
    assign inc   = {1'b0, opa_q} + {{WIDTH{1'b0}}, 1'b1};
    assign a_ext = {{WIDTH{1'b0}}, opa_q};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                          (sum[WIDTH-1] != opa_q[WIDTH-1]);
            end
            OP_INC: begin
                alu_res = inc[WIDTH-1:0];
                alu_c   = inc[WIDTH];
                alu_v   = (opa_q == {1'b0, {(WIDTH-1){1'b1}}});
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (opa_q[WIDTH-1] != opb_q[WIDTH-1]) &&
                          (diff[WIDTH-1] != opa_q[WIDTH-1]);
            end
            OP_MUL: alu_res = '0;
            OP_NOT: alu_res = ~opa_q;
            OP_XOR: alu_res = opa_q ^ opb_q;
            OP_OR:  alu_res = opa_q | opb_q;
            OP_AND: alu_res = opa_q & opb_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        res_d   = {{WIDTH{1'b0}}, alu_res};
        neg_d   = alu_res[WIDTH-1];
        carry_d = alu_c;
        ovf_d   = alu_v;
        if (op_q == OP_MUL) begin
            res_d   = acc_q;
            neg_d   = 1'b0;
            carry_d = 1'b0;
            ovf_d   = |acc_q[2*WIDTH-1:WIDTH];
        end
        zero_d = (res_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            neg      <= 1'b0;
            carry    <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= complete;
            if (!busy) begin
                if (load_a) a_q <= operand_in;
                if (load_b) b_q <= operand_in;
            end
            if (accept) begin
                op_q     <= op_t'(opcode);
                opa_q    <= a_q;
                opb_q    <= b_q;
                mplier_q <= b_q;
                acc_q    <= '0;
                count_q  <= '0;
            end
            if (mul_step) begin
                if (mplier_q[0]) acc_q <= acc_q + (a_ext << count_q);
                mplier_q <= mplier_q >> 1;
                count_q  <= count_q + CW'(1);
            end
            if (complete) begin
                result <= res_d;
                zero   <= zero_d;
                neg    <= neg_d;
                carry  <= carry_d;
                ovf    <= ovf_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= '0;
            idx_q <= '0;
        end else if (ref_q == RW'(REFRESH_DIV - 1)) begin
            ref_q <= '0;
            idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            ref_q <= ref_q + RW'(1);
        end
    end

    // Nibbles beyond the result width read as zero.
    always_comb begin
        res_pad                = '0;
        res_pad[2*WIDTH-1:0]   = result;
        nib                    = res_pad[{idx_q, 2'b00} +: 4];
        an_hot                 = '0;
        an_hot[idx_q]          = 1'b1;
        seg_an                 = ~an_hot;
    end

    always_comb begin
        seg_cat = 7'b1000000;
        unique case (nib)
            4'h0: seg_cat = 7'b1000000;
            4'h1: seg_cat = 7'b1111001;
            4'h2: seg_cat = 7'b0100100;
            4'h3: seg_cat = 7'b0110000;
            4'h4: seg_cat = 7'b0011001;
            4'h5: seg_cat = 7'b0010010;
            4'h6: seg_cat = 7'b0000010;
            4'h7: seg_cat = 7'b1111000;
            4'h8: seg_cat = 7'b0000000;
            4'h9: seg_cat = 7'b0010000;
            4'hA: seg_cat = 7'b0001000;
            4'hB: seg_cat = 7'b0000011;
            4'hC: seg_cat = 7'b1000110;
            4'hD: seg_cat = 7'b0100001;
            4'hE: seg_cat = 7'b0000110;
            4'hF: seg_cat = 7'b0001110;
            default: seg_cat = 7'b1000000;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_display.sv
// Bench for alu_seq_display: vector table, random ops against a reference
// model, and hand sequences for busy-time, reset and display behaviour.
module tb_alu_seq_display;

    localparam int W = 8;
    localparam int D = 4;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   operand_in = '0;
    logic [2:0]     opcode = '0;
    logic           load_a = 1'b0;
    logic           load_b = 1'b0;
    logic           start = 1'b0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           zero;
    logic           neg;
    logic           carry;
    logic           ovf;
    logic [6:0]     seg_cat;
    logic [D-1:0]   seg_an;

    int errors = 0;
    int checks = 0;

    alu_seq_display #(
        .WIDTH(W),
        .DIGITS(D),
        .REFRESH_DIV(R)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .operand_in(operand_in),
        .opcode(opcode),
        .load_a(load_a),
        .load_b(load_b),
        .start(start),
        .busy(busy),
        .done(done),
        .result(result),
        .zero(zero),
        .neg(neg),
        .carry(carry),
        .ovf(ovf),
        .seg_cat(seg_cat),
        .seg_an(seg_an)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned res;
        bit z;
        bit n;
        bit c;
        bit v;
    } exp_t;

    typedef struct {
        int          op;
        int unsigned a;
        int unsigned b;
        int unsigned res;
        bit z;
        bit n;
        bit c;
        bit v;
    } vec_t;

    logic [6:0] seg_tab [16];
    vec_t       tbl [14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int sgn(input int unsigned x);
        return (x >= 128) ? int'(x) - 256 : int'(x);
    endfunction

    // Reference computed from the arithmetic rules, not from the datapath.
    function automatic exp_t model(input int op, input int unsigned a,
                                   input int unsigned b);
        exp_t e;
        int   s;
        e.c = 0;
        e.v = 0;
        case (op)
            0: begin
                e.res = (a + b) % 256;
                e.c = (a + b) > 255;
                s = sgn(a) + sgn(b);
                e.v = (s > 127) || (s < -128);
            end
            1: begin
                e.res = (a + 1) % 256;
                e.c = (a == 255);
                e.v = (sgn(a) + 1) > 127;
            end
            2: begin
                e.res = (a + 256 - b) % 256;
                e.c = a < b;
                s = sgn(a) - sgn(b);
                e.v = (s > 127) || (s < -128);
            end
            3: begin
                e.res = a * b;
                e.v = e.res > 255;
            end
            4: e.res = 255 - a;
            5: e.res = a ^ b;
            6: e.res = a | b;
            default: e.res = a & b;
        endcase
        e.z = (e.res == 0);
        e.n = (op == 3) ? 1'b0 : 1'((e.res >> 7) & 1);
        return e;
    endfunction

    // Pulse start at the current negedge; returns edges to done and busy samples.
    task automatic fire(input int op, input bit noisy, output int k,
                        output int nb);
        opcode = 3'(op);
        start = 1'b1;
        k = 0;
        nb = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            load_a = 1'b0;
            load_b = 1'b0;
            k++;
            if (busy) nb++;
            if (noisy) begin
                opcode = 3'd0;
                operand_in = 8'h01;
                start = (k == 3);
                load_a = (k == 5);
                load_b = (k == 6);
            end
        end while (!done && k < 40);
        start = 1'b0;
        load_a = 1'b0;
        load_b = 1'b0;
    endtask

    task automatic check_res(input string nm, input int op, input exp_t e,
                             input int k, input int nb);
        chk({nm, " latency"}, k, (op == 3) ? 10 : 2);
        chk({nm, " busy"}, nb, (op == 3) ? 9 : 1);
        chk({nm, " result"}, result, e.res);
        chk({nm, " zero"}, zero, e.z);
        chk({nm, " neg"}, neg, e.n);
        chk({nm, " carry"}, carry, e.c);
        chk({nm, " ovf"}, ovf, e.v);
    endtask

    task automatic do_op(input string nm, input int op, input int unsigned a,
                         input int unsigned b, input exp_t e);
        int k;
        int nb;
        load_a = 1'b1;
        operand_in = W'(a);
        @(negedge clk);
        load_a = 1'b0;
        load_b = 1'b1;
        operand_in = W'(b);
        @(negedge clk);
        load_b = 1'b0;
        fire(op, 1'b0, k, nb);
        check_res(nm, op, e, k, nb);
        @(negedge clk);
        chk({nm, " done pulse"}, done, 1'b0);
    endtask

    initial begin
        exp_t e;
        int   k;
        int   nb;
        int   seen;
        logic [D-1:0] prev;

        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        tbl = '{
            '{0, 'h7F, 'h01, 'h0080, 0, 1, 0, 1},
            '{0, 'hFF, 'h01, 'h0000, 1, 0, 1, 0},
            '{2, 'h00, 'h01, 'h00FF, 0, 1, 1, 0},
            '{3, 'hFF, 'hFF, 'hFE01, 0, 0, 0, 1},
            '{1, 'h7F, 'h00, 'h0080, 0, 1, 0, 1},
            '{1, 'hFF, 'h00, 'h0000, 1, 0, 1, 0},
            '{2, 'h80, 'h01, 'h007F, 0, 0, 0, 1},
            '{2, 'h05, 'h05, 'h0000, 1, 0, 0, 0},
            '{3, 'h0F, 'h11, 'h00FF, 0, 0, 0, 0},
            '{3, 'h00, 'h37, 'h0000, 1, 0, 0, 0},
            '{4, 'h0F, 'h00, 'h00F0, 0, 1, 0, 0},
            '{5, 'hA5, 'hFF, 'h005A, 0, 0, 0, 0},
            '{6, 'hA0, 'h05, 'h00A5, 0, 1, 0, 0},
            '{7, 'hF0, 'h3C, 'h0030, 0, 0, 0, 0}
        };

        repeat (3) @(negedge clk);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst result", result, 16'h0000);
        chk("rst zero", zero, 1'b0);
        chk("rst flags", {neg, carry, ovf}, 3'b000);
        chk("rst seg_an", seg_an, 4'b1110);
        chk("rst seg_cat", seg_cat, 7'b1000000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post rst busy", busy, 1'b0);

        foreach (tbl[i]) begin
            e.res = tbl[i].res;
            e.z = tbl[i].z;
            e.n = tbl[i].n;
            e.c = tbl[i].c;
            e.v = tbl[i].v;
            do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, e);
        end

        for (int i = 0; i < 60; i++) begin
            int op;
            int unsigned a;
            int unsigned b;
            op = $urandom_range(0, 7);
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            do_op($sformatf("rnd%0d op%0d %0h %0h", i, op, a, b), op, a, b,
                  model(op, a, b));
        end

        // Same-cycle load with start only affects the following start.
        load_a = 1'b1;
        operand_in = 8'h10;
        @(negedge clk);
        load_a = 1'b0;
        load_b = 1'b1;
        operand_in = 8'h01;
        @(negedge clk);
        load_b = 1'b0;
        load_a = 1'b1;
        operand_in = 8'h20;
        fire(0, 1'b0, k, nb);
        chk("same-cycle load old A", result, 16'h0011);
        @(negedge clk);
        fire(0, 1'b0, k, nb);
        chk("same-cycle load next A", result, 16'h0021);
        @(negedge clk);

        // Starts and loads during a multiply are ignored and not queued.
        load_a = 1'b1;
        operand_in = 8'hFF;
        @(negedge clk);
        load_a = 1'b0;
        load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
        fire(3, 1'b1, k, nb);
        check_res("noisy mul", 3, model(3, 'hFF, 'hFF), k, nb);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("no queued start", seen, 0);
        do_op("reload mul", 3, 'h02, 'hFF, model(3, 'h02, 'hFF));

        // Reset in the middle of a multiply.
        load_a = 1'b1;
        operand_in = 8'hFF;
        @(negedge clk);
        load_a = 1'b0;
        load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
        opcode = 3'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort result", result, 16'h0000);
        chk("abort flags", {zero, neg, carry, ovf}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("abort no done", seen, 0);
        fire(0, 1'b0, k, nb);
        e.res = 0;
        e.z = 1;
        e.n = 0;
        e.c = 0;
        e.v = 0;
        check_res("after abort", 0, e, k, nb);
        @(negedge clk);

        // Display scan of 0x12AB.
        do_op("disp mul", 3, 'h51, 'h3B, model(3, 'h51, 'h3B));
        k = 0;
        prev = seg_an;
        do begin
            @(negedge clk);
            k++;
            if (seg_an == 4'b1110 && prev != 4'b1110) break;
            prev = seg_an;
        end while (k < 40);
        chk("disp sync", 32'(k < 40), 1);
        for (int i = 0; i <= 16; i++) begin
            int d;
            logic [D-1:0] an;
            logic [15:0] rv;
            d = (i / 4) % 4;
            an = ~(D'(1) << d);
            rv = 16'h12AB;
            if (i > 0) @(negedge clk);
            chk($sformatf("disp an %0d", i), seg_an, an);
            chk($sformatf("disp cat %0d", i), seg_cat, seg_tab[(rv >> (4 * d)) & 15]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
